// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage controller for big-endian data memory.
// Runs a req/ack transaction for loads/stores and stalls the pipeline meanwhile.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        EX_valid_in,
    input  logic [31:0] EX_ALU_in,
    input  logic [31:0] EX_DI_in,
    input  logic [4:0]  EX_RD_in,
    input  logic        EX_RF_LE_in,
    input  logic        EX_LOAD_in,
    input  logic        EX_STORE_in,
    input  logic [1:0]  EX_SIZE_in,
    input  logic        EX_SE_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] MEM_PD_out,
    output logic [4:0]  MEM_RD_out,
    output logic        MEM_RF_LE_out,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [31:0] ldata_q;
    logic        err_q;

    logic        is_load;
    logic        is_store;
    logic        memop;
    logic [1:0]  ofs;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        aligned;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] lane;
    logic [7:0]  b8;
    logic [15:0] h16;

    // Load wins when both load and store are flagged.
    assign is_load  = EX_LOAD_in;
    assign is_store = EX_STORE_in & ~EX_LOAD_in;
    assign memop    = EX_valid_in & (EX_LOAD_in | EX_STORE_in);
    assign ofs      = EX_ALU_in[1:0];
    assign is_byte  = (EX_SIZE_in == 2'b00);
    assign is_half  = (EX_SIZE_in == 2'b01);
    assign is_word  = EX_SIZE_in[1];
    assign aligned  = is_byte
                    | (is_half & ~ofs[0])
                    | (is_word & (ofs == 2'b00));

    assign mem_addr  = {EX_ALU_in[31:2], 2'b00};
    assign mem_wdata = wdata;

    // Byte enables and lane-replicated store data.
    always_comb begin
        be    = 4'b1111;
        wdata = EX_DI_in;
        unique case (1'b1)
            is_byte: begin
                be    = 4'b1000 >> ofs;
                wdata = {4{EX_DI_in[7:0]}};
            end
            is_half: begin
                be    = ofs[1] ? 4'b0011 : 4'b1100;
                wdata = {2{EX_DI_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Big-endian lane select plus sign/zero extension of read data.
    always_comb begin
        lane = mem_rdata;
        b8   = mem_rdata[31:24];
        h16  = mem_rdata[31:16];
        unique case (1'b1)
            is_byte: begin
                unique case (ofs)
                    2'd0: b8 = mem_rdata[31:24];
                    2'd1: b8 = mem_rdata[23:16];
                    2'd2: b8 = mem_rdata[15:8];
                    default: b8 = mem_rdata[7:0];
                endcase
                lane = {{24{EX_SE_in & b8[7]}}, b8};
            end
            is_half: begin
                h16  = ofs[1] ? mem_rdata[15:0] : mem_rdata[31:16];
                lane = {{16{EX_SE_in & h16[15]}}, h16};
            end
            default: ;
        endcase
    end

    // Transaction FSM: wait counter, captured load data, timeout flag.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ldata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (memop && aligned) begin
                        state_q <= REQ;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        ldata_q <= lane;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else if (cnt_q == TMO_LAST) begin
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output decode; stall/misalign are suppressed while reset is held.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_be        = 4'b0000;
        MEM_PD_out    = EX_ALU_in;
        MEM_RD_out    = EX_RD_in;
        MEM_RF_LE_out = 1'b0;
        stall         = 1'b0;
        misalign      = 1'b0;
        bus_err       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!memop) begin
                    MEM_RF_LE_out = EX_RF_LE_in & EX_valid_in;
                end else if (aligned) begin
                    stall = Reset;
                end else begin
                    misalign = Reset;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                mem_be  = be;
                stall   = 1'b1;
            end
            DONE: begin
                if (is_load) begin
                    MEM_PD_out = ldata_q;
                end
                MEM_RF_LE_out = EX_RF_LE_in & ~err_q;
                bus_err       = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed plus randomized checks of mem_access_stage
// against a byte-arithmetic reference model.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        Reset;
    logic        EX_valid_in;
    logic [31:0] EX_ALU_in;
    logic [31:0] EX_DI_in;
    logic [4:0]  EX_RD_in;
    logic        EX_RF_LE_in;
    logic        EX_LOAD_in;
    logic        EX_STORE_in;
    logic [1:0]  EX_SIZE_in;
    logic        EX_SE_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] MEM_PD_out;
    logic [4:0]  MEM_RD_out;
    logic        MEM_RF_LE_out;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .Reset(Reset),
        .EX_valid_in(EX_valid_in), .EX_ALU_in(EX_ALU_in),
        .EX_DI_in(EX_DI_in), .EX_RD_in(EX_RD_in),
        .EX_RF_LE_in(EX_RF_LE_in), .EX_LOAD_in(EX_LOAD_in),
        .EX_STORE_in(EX_STORE_in), .EX_SIZE_in(EX_SIZE_in),
        .EX_SE_in(EX_SE_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .MEM_PD_out(MEM_PD_out), .MEM_RD_out(MEM_RD_out),
        .MEM_RF_LE_out(MEM_RF_LE_out), .stall(stall),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes and big-endian byte offset.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int offs(input logic [31:0] a, input logic [1:0] sz);
        int n = nbytes(sz);
        int m = int'(a % 4);
        return m - (m % n);
    endfunction

    function automatic logic [3:0] exp_be(input logic [31:0] a,
                                          input logic [1:0] sz);
        int n = nbytes(sz);
        int v = ((1 << n) - 1) << (4 - n - offs(a, sz));
        return v[3:0];
    endfunction

    function automatic logic [31:0] exp_wd(input logic [31:0] di,
                                           input logic [1:0] sz);
        int n = nbytes(sz);
        if (n == 1) return {24'd0, di[7:0]} * 32'h01010101;
        if (n == 2) return {16'd0, di[15:0]} * 32'h00010001;
        return di;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [31:0] rd,
                                           input logic [31:0] a,
                                           input logic [1:0] sz,
                                           input logic se);
        int n = nbytes(sz);
        logic [63:0] v;
        logic [63:0] mask;
        v    = {32'd0, rd} >> (8 * (4 - n - offs(a, sz)));
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = v & mask;
        if (se && n < 4 && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic set_ex(input logic v, input logic [31:0] alu,
                          input logic [31:0] di, input logic [4:0] rd,
                          input logic le, input logic ld, input logic st,
                          input logic [1:0] sz, input logic se);
        EX_valid_in = v;   EX_ALU_in = alu;  EX_DI_in = di;
        EX_RD_in    = rd;  EX_RF_LE_in = le; EX_LOAD_in = ld;
        EX_STORE_in = st;  EX_SIZE_in = sz;  EX_SE_in = se;
    endtask

    task automatic alu_op(input logic v, input logic [31:0] alu,
                          input logic [4:0] rd, input logic le,
                          input logic ld, input logic st);
        @(posedge clk); #2;
        set_ex(v, alu, 32'h0, rd, le, ld & ~v, st & ~v, 2'd2, 1'b0);
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
        #1;
        chk("alu_pd", MEM_PD_out, alu);
        chk("alu_rd", 32'(MEM_RD_out), 32'(rd));
        chk("alu_le", 32'(MEM_RF_LE_out), 32'(le & v));
        chk("alu_stall", 32'(stall), 0);
        chk("alu_req", 32'(mem_req), 0);
        chk("alu_mis", 32'(misalign), 0);
    endtask

    // One memory instruction; ackd = REQ cycle index of ack (>= TO: none).
    task automatic do_mem(input logic [31:0] alu, input logic [31:0] di,
                          input logic [4:0] rd, input logic le,
                          input logic ld, input logic st,
                          input logic [1:0] sz, input logic se,
                          input logic [31:0] rdat, input int ackd);
        int n = nbytes(sz);
        bit mis = (alu % n) != 0;
        bit acked = ackd < TO;
        int last = acked ? ackd : TO - 1;
        int stalls = 0;
        bit is_ld = ld;
        @(posedge clk); #2;
        set_ex(1'b1, alu, di, rd, le, ld, st, sz, se);
        mem_ack = 1'b0;
        #1;
        if (mis) begin
            chk("mis_pulse", 32'(misalign), 1);
            chk("mis_stall", 32'(stall), 0);
            chk("mis_req", 32'(mem_req), 0);
            chk("mis_le", 32'(MEM_RF_LE_out), 0);
            @(posedge clk); #2;
            EX_valid_in = 1'b0;
            #1;
            chk("mis_req2", 32'(mem_req), 0);
            chk("mis_pulse2", 32'(misalign), 0);
            return;
        end
        chk("idle_stall", 32'(stall), 1);
        chk("idle_le", 32'(MEM_RF_LE_out), 0);
        chk("idle_req", 32'(mem_req), 0);
        if (stall) stalls++;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #2;
            mem_ack = (k == ackd);
            mem_rdata = (k == ackd) ? rdat : $urandom;
            #1;
            chk("req_req", 32'(mem_req), 1);
            chk("req_we", 32'(mem_we), 32'(st & ~ld));
            chk("req_addr", mem_addr, alu & ~32'h3);
            chk("req_be", 32'(mem_be), 32'(exp_be(alu, sz)));
            chk("req_wd", mem_wdata, exp_wd(di, sz));
            chk("req_berr", 32'(bus_err), 0);
            if (stall) stalls++;
        end
        @(posedge clk); #2;
        mem_ack = 1'b1;
        mem_rdata = $urandom;
        #1;
        chk("done_stall", 32'(stall), 0);
        chk("done_req", 32'(mem_req), 0);
        chk("done_berr", 32'(bus_err), 32'(!acked));
        chk("done_rd", 32'(MEM_RD_out), 32'(rd));
        chk("done_le", 32'(MEM_RF_LE_out), 32'(acked ? le : 1'b0));
        if (acked)
            chk("done_pd", MEM_PD_out,
                is_ld ? exp_ld(rdat, alu, sz, se) : alu);
        chk("stall_cycles", 32'(stalls), 32'(last + 2));
        @(posedge clk); #2;
        mem_ack = 1'b0;
        EX_valid_in = 1'b0;
        #1;
        chk("back_idle_req", 32'(mem_req), 0);
        chk("back_idle_berr", 32'(bus_err), 0);
    endtask

    initial begin
        Reset = 1'b0;
        set_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        #3;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_be", 32'(mem_be), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_mis", 32'(misalign), 0);
        chk("rst_berr", 32'(bus_err), 0);
        #9;
        Reset = 1'b1;

        alu_op(1'b1, 32'h12345678, 5'd5, 1'b1, 1'b0, 1'b0);
        do_mem(32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0,
               32'hDEADBEEF, 1);
        do_mem(32'h103, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1,
               32'h000000F0, 0);
        do_mem(32'h103, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0,
               32'h000000F0, 0);
        do_mem(32'h202, 32'h0000ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1,
               1'b0, 32'h0, 0);
        do_mem(32'h101, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0,
               32'h0, 0);
        do_mem(32'h300, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0,
               32'h0, 99);

        // Reset in the middle of a request.
        @(posedge clk); #2;
        set_ex(1'b1, 32'h400, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        mem_ack = 1'b0;
        @(posedge clk); #2;
        chk("mid_req_on", 32'(mem_req), 1);
        Reset = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 0);
        chk("mid_rst_stall", 32'(stall), 0);
        @(posedge clk); #2;
        chk("mid_rst_req2", 32'(mem_req), 0);
        chk("mid_rst_berr", 32'(bus_err), 0);
        EX_valid_in = 1'b0;
        Reset = 1'b1;
        alu_op(1'b1, 32'hCAFEF00D, 5'd17, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int kind = int'($urandom_range(0, 3));
            logic [31:0] a = $urandom;
            logic [4:0] r = 5'($urandom);
            logic le = 1'($urandom);
            if (kind == 0) begin
                alu_op(1'($urandom), a, r, le, 1'($urandom), 1'($urandom));
            end else begin
                logic ld = 1'($urandom);
                logic st = ld ? 1'($urandom) : 1'b1;
                do_mem(a, $urandom, r, le, ld, st, 2'($urandom),
                       1'($urandom), $urandom,
                       int'($urandom_range(0, TO + 2)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage controller between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Pass-through ALU results: forwarded combinationally to the MEM/WB inputs.
- Loads and stores: runs a req/ack transaction with data memory and stalls the upstream pipeline until the transaction completes.
- Big-endian byte/halfword/word access with lane formatting, sign/zero extension, alignment check and ack timeout.

Parameters:
- TIMEOUT, 15, REQ-state cycles to wait for mem_ack before aborting (1..255).

Ports:
- clk  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- EX_valid_in  in  1  EX/MEM slot holds a real instruction.
- EX_ALU_in  in  32  ALU result / effective address.
- EX_DI_in  in  32  store data.
- EX_RD_in  in  5  destination register.
- EX_RF_LE_in  in  1  register-file load enable.
- EX_LOAD_in  in  1  instruction is a load.
- EX_STORE_in  in  1  instruction is a store.
- EX_SIZE_in  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- EX_SE_in  in  1  sign-extend load data.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_addr  out  32  word-aligned address (EX_ALU_in with [1:0] = 00).
- mem_be  out  4  byte enables, bit3 = bits[31:24].
- mem_wdata  out  32  store data replicated into lanes.
- mem_ack  in  1  transaction complete; rdata valid this cycle.
- mem_rdata  in  32  read data.
- MEM_PD_out  out  32  to MEM/WB PD input.
- MEM_RD_out  out  5  to MEM/WB RD input.
- MEM_RF_LE_out  out  1  to MEM/WB RF_LE input.
- stall  out  1  freeze PC/IF/ID/EX and EX/MEM; hold MEM/WB inputs at their current values.
- misalign  out  1  one-cycle pulse: misaligned access.
- bus_err  out  1  one-cycle pulse: ack timeout.

Behaviour:
- Reset (Reset=0, async):
  - State goes to IDLE; counter and load-data register cleared to 0.
  - mem_req, mem_we, mem_be = 0; misalign, bus_err = 0; stall = 0.
- Memory-op definition: memop = EX_valid_in & (EX_LOAD_in | EX_STORE_in). LOAD takes precedence if both are set.
- Alignment:
  - Halfword needs addr[0] = 0.
  - Word needs addr[1:0] = 00.
  - Byte is always aligned.
- State IDLE:
  - Non-memop: MEM_PD_out = EX_ALU_in, MEM_RD_out = EX_RD_in, MEM_RF_LE_out = EX_RF_LE_in & EX_valid_in, stall = 0.
  - Aligned memop: stall = 1, MEM_RF_LE_out = 0, next state REQ.
  - Misaligned memop: no memory access, misalign = 1 for this cycle, MEM_RF_LE_out = 0, stall = 0, state stays IDLE (instruction retires as a no-op).
- State REQ:
  - Outputs:
    - mem_req = 1, stall = 1, MEM_RF_LE_out = 0.
    - mem_we = store, mem_addr = {EX_ALU_in[31:2], 2'b00}.
    - mem_be: byte → 1000 >> addr[1:0]; half → 1100 (addr[1] = 0) or 0011 (addr[1] = 1); word → 1111.
    - mem_wdata: byte → {4{DI[7:0]}}; half → {2{DI[15:0]}}; word → DI.
  - Counter increments each REQ cycle.
  - mem_ack = 1: capture the formatted load data, clear the counter, next state DONE.
  - Else if counter == TIMEOUT-1: go to DONE with the error flag set (bus_err pulses for one cycle at the DONE entry edge, registered).
- State DONE:
  - stall = 0; MEM_RD_out = EX_RD_in.
  - Load: MEM_PD_out = load-data register, MEM_RF_LE_out = EX_RF_LE_in.
  - Store: MEM_PD_out = EX_ALU_in, MEM_RF_LE_out = EX_RF_LE_in.
  - Error: MEM_RF_LE_out = 0.
  - Next state IDLE unconditionally. Upstream advances on this edge.
- Load formatting (big-endian lane select):
  - Byte lane by addr[1:0]: 00 → [31:24] … 11 → [7:0].
  - Half: addr[1] = 0 → [31:16], else [15:0].
  - Extend to 32 bits by sign (EX_SE_in = 1) or zero.
- Latency: aligned memop with ack in the first REQ cycle occupies 3 cycles (IDLE, REQ, DONE). Each additional wait cycle adds 1.
- Boundary conditions:
  - mem_ack outside REQ is ignored.
  - EX inputs are held stable by the stall while in REQ/DONE; they are not re-sampled except as stated above.
  - Reset asserted mid-REQ aborts: mem_req drops immediately (async), no result is produced.
  - Back-to-back memops: the second enters IDLE on the cycle after DONE and stalls again. No overlap.

Test Plan:
- ALU op: valid, ALU = 0x12345678, RD = 5, RF_LE = 1 → same cycle PD = 0x12345678, RD = 5, RF_LE = 1, stall = 0, mem_req = 0.
- Word load from addr 0x100, ack 2 cycles after REQ entry, rdata = 0xDEADBEEF → mem_be = 1111; stall high for 3 cycles; DONE gives PD = 0xDEADBEEF, RF_LE = 1.
- Signed byte load:
  - addr 0x103, rdata = 0x000000F0, SE = 1 → PD = 0xFFFFFFF0.
  - Same access with SE = 0 → PD = 0x000000F0.
  - Both cases: mem_be = 0001.
- Halfword store: addr 0x202, DI = 0x0000ABCD → mem_we = 1, mem_addr = 0x200, mem_be = 0011, wdata = 0xABCDABCD.
- Misaligned word at 0x101 → misalign pulse, mem_req never asserts, RF_LE_out = 0, stall = 0. Timeout: load with no ack and TIMEOUT = 4 → 4 REQ cycles, bus_err pulse, RF_LE_out = 0, return to IDLE.
- Reset asserted (low) during REQ → mem_req = 0 and stall = 0 immediately. After release, an ALU op passes through normally.
